// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the PC controller: opcodes, transfer classes, resolve latency range.
// Optional statistics counters are built when PC_CTRL_STATS_EN is defined.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    JON_NONE     = 2'b00,
    JON_DIRECT   = 2'b01,
    JON_COND     = 2'b10,
    JON_INDIRECT = 2'b11
  } jon_e;

  localparam logic [5:0] OP_BEQ  = 6'd32;
  localparam logic [5:0] OP_BNE  = 6'd33;
  localparam logic [5:0] OP_BLTU = 6'd34;
  localparam logic [5:0] OP_BLEU = 6'd35;
  localparam logic [5:0] OP_BLT  = 6'd36;
  localparam logic [5:0] OP_BLE  = 6'd37;
  localparam logic [5:0] OP_JR   = 6'd42;

  localparam int RESOLVE_LAT_MIN = 1;
  localparam int RESOLVE_LAT_MAX = 7;
  localparam int CNT_W           = 3;

  // Out-of-range latencies are pulled into the legal window so the counter never overflows.
  function automatic int clamp_lat(input int lat);
    if (lat < RESOLVE_LAT_MIN) return RESOLVE_LAT_MIN;
    if (lat > RESOLVE_LAT_MAX) return RESOLVE_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/pc_ctrl_cmp.sv
// Combinational branch-condition evaluator; taken is 0 for any non-conditional opcode.
module pc_cmp
  import pc_ctrl_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [5:0]    op,
  input  logic [AW-1:0] os,
  input  logic [AW-1:0] ot,
  output logic          taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = (os == ot);
      OP_BNE:  taken = (os != ot);
      OP_BLTU: taken = (os < ot);
      OP_BLEU: taken = (os <= ot);
      OP_BLT:  taken = ($signed(os) < $signed(ot));
      OP_BLE:  taken = ($signed(os) <= $signed(ot));
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch PC controller: direct jumps, delayed resolution of conditional/indirect transfers.
// Define PC_CTRL_STATS_EN to add saturating n_resolved / n_taken counters.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int AW          = 32,
  parameter int RESOLVE_LAT = 2,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        jon_d,
  input  logic [25:0]       addr_d,
  input  logic [5:0]        op,
  input  logic [AW-1:0]     os,
  input  logic [AW-1:0]     ot,
  input  logic [AW-1:0]     imm_dpl,
  input  logic [AW-1:0]     pc_in,
  output logic [AW-1:0]     pc_out,
  output logic              pending,
  output logic              redirect
`ifdef PC_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] n_resolved,
  output logic [STAT_W-1:0] n_taken
`endif
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(clamp_lat(RESOLVE_LAT));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    pc_d, nonbranch, branch, target, jump_pc;
  logic             cond_taken, direct, resolve, redirect_d;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^addr_d[1:0];
  assign pending         = (cnt_q != '0);

  pc_cmp #(.AW(AW)) u_cmp (
    .op    (op),
    .os    (os),
    .ot    (ot),
    .taken (cond_taken)
  );

  // A direct jump always wins; a resolution only redirects when it leaves the fall-through path.
  always_comb begin
    nonbranch  = pc_in + AW'(1);
    branch     = nonbranch + AW'($signed(imm_dpl) >>> 2);
    target     = nonbranch;
    if (op == OP_JR)
      target = os;
    else if (cond_taken)
      target = branch;

    direct     = (jon_d == JON_DIRECT);
    resolve    = (cnt_q == CNT_W'(1)) && !flush;
    jump_pc    = AW'(addr_d[25:2]);

    pc_d = pc_out + AW'(1);
    if (direct)
      pc_d = jump_pc;
    else if (resolve)
      pc_d = target;

    redirect_d = resolve && !direct && (target != nonbranch);

    cnt_d = cnt_q;
    if (jon_d[1])
      cnt_d = LAT_LOAD;
    else if (flush)
      cnt_d = '0;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      pc_out   <= '0;
      cnt_q    <= '0;
      redirect <= 1'b0;
    end else if (stall) begin
      redirect <= 1'b0;
    end else begin
      pc_out   <= pc_d;
      cnt_q    <= cnt_d;
      redirect <= redirect_d;
    end
  end

`ifdef PC_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      n_resolved <= '0;
      n_taken    <= '0;
    end else if (!stall) begin
      if (resolve && (n_resolved != '1))
        n_resolved <= n_resolved + STAT_W'(1);
      if (redirect_d && (n_taken != '1))
        n_taken <= n_taken + STAT_W'(1);
    end
  end
`else
  localparam int unused_stat_w = STAT_W;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_pc_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  jon_d = 2'b00;
  logic [25:0] addr_d = '0;
  logic [5:0]  op = '0;
  logic [31:0] os = '0, ot = '0, imm_dpl = '0, pc_in = '0;
  logic [31:0] pc_out;
  logic        pending, redirect;
`ifdef PC_CTRL_STATS_EN
  logic [15:0] n_resolved, n_taken;
`endif

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_red;
  int          m_nres, m_ntak;

  pc_ctrl #(.AW(32), .RESOLVE_LAT(LAT), .STAT_W(16)) dut (
    .clk      (clk),
    .rstd     (rstd),
    .stall    (stall),
    .flush    (flush),
    .jon_d    (jon_d),
    .addr_d   (addr_d),
    .op       (op),
    .os       (os),
    .ot       (ot),
    .imm_dpl  (imm_dpl),
    .pc_in    (pc_in),
    .pc_out   (pc_out),
    .pending  (pending),
    .redirect (redirect)
`ifdef PC_CTRL_STATS_EN
    ,
    .n_resolved (n_resolved),
    .n_taken    (n_taken)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_target(input logic [5:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] imm,
                                             input logic [31:0] pcin);
    longint nb, br;
    bit     t;
    nb = (longint'(pcin) + 1) & 64'hFFFF_FFFF;
    br = (nb + (longint'(int'(imm)) >>> 2)) & 64'hFFFF_FFFF;
    case (o)
      6'd32: t = (a == b);
      6'd33: t = (a != b);
      6'd34: t = (a < b);
      6'd35: t = (a <= b);
      6'd36: t = (int'(a) < int'(b));
      6'd37: t = (int'(a) <= int'(b));
      6'd42: return a;
      default: return nb[31:0];
    endcase
    return t ? br[31:0] : nb[31:0];
  endfunction

  task automatic model_reset();
    m_pc = '0; m_cnt = 0; m_red = 0; m_nres = 0; m_ntak = 0;
  endtask

  // Advance one clock: model consumes the inputs present before the edge.
  task automatic tick();
    logic [31:0] nb, tgt, npc;
    int  ncnt, nres, ntak;
    bit  nred, res, dir;
    npc = m_pc; ncnt = m_cnt; nred = 0; nres = m_nres; ntak = m_ntak;
    if (!stall) begin
      nb  = pc_in + 32'd1;
      tgt = ref_target(op, os, ot, imm_dpl, pc_in);
      res = (m_cnt == 1) && !flush;
      dir = (jon_d == 2'b01);
      if (dir)      npc = {6'b0, addr_d[25:2]};
      else if (res) npc = tgt;
      else          npc = m_pc + 32'd1;
      nred = res && !dir && (tgt != nb);
      if (jon_d[1])       ncnt = LAT;
      else if (flush)     ncnt = 0;
      else if (m_cnt > 0) ncnt = m_cnt - 1;
      if (res && nres < 65535)  nres++;
      if (nred && ntak < 65535) ntak++;
    end
    @(posedge clk);
    #1;
    m_pc = npc; m_cnt = ncnt; m_red = nred; m_nres = nres; m_ntak = ntak;
  endtask

  task automatic test_reset();
    rstd = 1'b0;
    #12;
    checks++; if (pc_out !== 32'h0) $display("[TB] FAIL reset_pc: got %h expected %h", pc_out, 32'h0); else passed++;
    checks++; if (pending !== 1'b0) $display("[TB] FAIL reset_pending: got %b expected 0", pending); else passed++;
    checks++; if (redirect !== 1'b0) $display("[TB] FAIL reset_redirect: got %b expected 0", redirect); else passed++;
    rstd = 1'b1;
    model_reset();
    checks++; if (pc_out !== 32'h0) $display("[TB] FAIL first_fetch: got %h expected %h", pc_out, 32'h0); else passed++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pc_out !== 32'(i)) $display("[TB] FAIL seq_pc%0d: got %h expected %h", i, pc_out, 32'(i)); else passed++;
      checks++; if (pending !== 1'b0) $display("[TB] FAIL seq_pending%0d: got %b expected 0", i, pending); else passed++;
    end
  endtask

  task automatic test_direct();
    jon_d = 2'b01; addr_d = 26'h100;
    tick();
    jon_d = 2'b00;
    checks++; if (pc_out !== 32'h40) $display("[TB] FAIL direct_pc: got %h expected %h", pc_out, 32'h40); else passed++;
    checks++; if (redirect !== 1'b0) $display("[TB] FAIL direct_redirect: got %b expected 0", redirect); else passed++;
    tick();
    checks++; if (pc_out !== 32'h41) $display("[TB] FAIL direct_next: got %h expected %h", pc_out, 32'h41); else passed++;
  endtask

  task automatic test_cond_branch();
    jon_d = 2'b10; tick(); jon_d = 2'b00;
    checks++; if (pending !== 1'b1) $display("[TB] FAIL cond_pending: got %b expected 1", pending); else passed++;
    tick();
    op = 6'd36; os = 32'hFFFF_FFFF; ot = 32'h0; pc_in = 32'h10; imm_dpl = 32'hFFFF_FFF8;
    tick();
    checks++; if (pc_out !== 32'h0F) $display("[TB] FAIL blt_pc: got %h expected %h", pc_out, 32'h0F); else passed++;
    checks++; if (redirect !== 1'b1) $display("[TB] FAIL blt_redirect: got %b expected 1", redirect); else passed++;
    checks++; if (pending !== 1'b0) $display("[TB] FAIL blt_pending: got %b expected 0", pending); else passed++;
    op = 6'd0;
    tick();
    checks++; if (redirect !== 1'b0) $display("[TB] FAIL blt_pulse: got %b expected 0", redirect); else passed++;
    checks++; if (pc_out !== 32'h10) $display("[TB] FAIL blt_after: got %h expected %h", pc_out, 32'h10); else passed++;
    jon_d = 2'b10; tick(); jon_d = 2'b00; tick();
    op = 6'd34;
    tick();
    checks++; if (pc_out !== 32'h11) $display("[TB] FAIL bltu_pc: got %h expected %h", pc_out, 32'h11); else passed++;
    checks++; if (redirect !== 1'b0) $display("[TB] FAIL bltu_redirect: got %b expected 0", redirect); else passed++;
    op = 6'd0;
  endtask

  task automatic test_stall();
    logic [31:0] held;
    jon_d = 2'b10; tick(); jon_d = 2'b00; tick();
    held = m_pc;
    op = 6'd42; os = 32'h200; pc_in = 32'h50;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      jon_d = (i == 1) ? 2'b10 : 2'b00;
      tick();
      checks++; if (pc_out !== held) $display("[TB] FAIL stall_pc%0d: got %h expected %h", i, pc_out, held); else passed++;
      checks++; if (pending !== 1'b1) $display("[TB] FAIL stall_pending%0d: got %b expected 1", i, pending); else passed++;
    end
    jon_d = 2'b00; stall = 1'b0;
    tick();
    checks++; if (pc_out !== 32'h200) $display("[TB] FAIL stall_release_pc: got %h expected %h", pc_out, 32'h200); else passed++;
    checks++; if (redirect !== 1'b1) $display("[TB] FAIL stall_release_redirect: got %b expected 1", redirect); else passed++;
    op = 6'd0;
  endtask

  task automatic test_priority();
    logic [31:0] exp_pc;
    jon_d = 2'b10; tick(); jon_d = 2'b00; tick();
    op = 6'd42; os = 32'h300; pc_in = 32'h60;
    jon_d = 2'b01; addr_d = 26'h80;
    tick();
    jon_d = 2'b00;
    checks++; if (pc_out !== 32'h20) $display("[TB] FAIL prio_pc: got %h expected %h", pc_out, 32'h20); else passed++;
    checks++; if (pending !== 1'b0) $display("[TB] FAIL prio_pending: got %b expected 0", pending); else passed++;
    checks++; if (redirect !== 1'b0) $display("[TB] FAIL prio_redirect: got %b expected 0", redirect); else passed++;
    jon_d = 2'b10; tick(); jon_d = 2'b00; tick();
    exp_pc = m_pc + 32'd1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (pc_out !== exp_pc) $display("[TB] FAIL flush_pc: got %h expected %h", pc_out, exp_pc); else passed++;
    checks++; if (redirect !== 1'b0) $display("[TB] FAIL flush_redirect: got %b expected 0", redirect); else passed++;
    checks++; if (pending !== 1'b0) $display("[TB] FAIL flush_pending: got %b expected 0", pending); else passed++;
    jon_d = 2'b10; tick(); jon_d = 2'b00; tick();
    flush = 1'b1; jon_d = 2'b11;
    tick();
    flush = 1'b0; jon_d = 2'b00;
    checks++; if (pending !== 1'b1) $display("[TB] FAIL flush_load_pending: got %b expected 1", pending); else passed++;
    tick(); tick();
    checks++; if (redirect !== 1'b1) $display("[TB] FAIL flush_load_redirect: got %b expected 1", redirect); else passed++;
    checks++; if (pc_out !== 32'h300) $display("[TB] FAIL flush_load_pc: got %h expected %h", pc_out, 32'h300); else passed++;
    op = 6'd0;
  endtask

  task automatic test_reset_mid();
    jon_d = 2'b10; tick(); jon_d = 2'b00;
    checks++; if (pending !== 1'b1) $display("[TB] FAIL mid_pending_before: got %b expected 1", pending); else passed++;
    #2;
    rstd = 1'b0;
    model_reset();
    #1;
    checks++; if (pc_out !== 32'h0) $display("[TB] FAIL mid_reset_pc: got %h expected %h", pc_out, 32'h0); else passed++;
    checks++; if (pending !== 1'b0) $display("[TB] FAIL mid_reset_pending: got %b expected 0", pending); else passed++;
    checks++; if (redirect !== 1'b0) $display("[TB] FAIL mid_reset_redirect: got %b expected 0", redirect); else passed++;
`ifdef PC_CTRL_STATS_EN
    checks++; if (n_resolved !== 16'd0) $display("[TB] FAIL mid_reset_nres: got %0d expected 0", n_resolved); else passed++;
    checks++; if (n_taken !== 16'd0) $display("[TB] FAIL mid_reset_ntak: got %0d expected 0", n_taken); else passed++;
`endif
    @(negedge clk);
    rstd = 1'b1;
    tick();
    checks++; if (pc_out !== 32'h1) $display("[TB] FAIL mid_release_pc: got %h expected %h", pc_out, 32'h1); else passed++;
  endtask

`ifdef PC_CTRL_STATS_EN
  task automatic test_stats();
    for (int k = 0; k < 5; k++) begin
      jon_d = 2'b10; tick(); jon_d = 2'b00; tick();
      op = (k < 3) ? 6'd42 : 6'd32;
      os = 32'h1000 + 32'(k); ot = 32'h0; pc_in = 32'h0;
      tick();
    end
    op = 6'd0;
    checks++; if (n_resolved !== 16'd5) $display("[TB] FAIL stats_nres: got %0d expected 5", n_resolved); else passed++;
    checks++; if (n_taken !== 16'd3) $display("[TB] FAIL stats_ntak: got %0d expected 3", n_taken); else passed++;
  endtask
`endif

  task automatic test_random();
    logic [5:0] ops [8];
    int r;
    ops = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd42, 6'd0};
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 11) == 0);
      r = $urandom_range(0, 9);
      jon_d = (r < 6) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      addr_d = 26'($urandom);
      op = ops[$urandom_range(0, 7)];
      if (op == 6'd0) op = 6'($urandom);
      os = $urandom;
      r = $urandom_range(0, 2);
      ot = (r == 0) ? os : (r == 1) ? os + 32'd1 : $urandom;
      imm_dpl = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      pc_in = $urandom_range(0, 1) ? $urandom : os - 32'd1;
      tick();
      checks++; if (pc_out !== m_pc) $display("[TB] FAIL rand_pc%0d: got %h expected %h", i, pc_out, m_pc); else passed++;
      checks++; if (pending !== (m_cnt != 0)) $display("[TB] FAIL rand_pending%0d: got %b expected %b", i, pending, m_cnt != 0); else passed++;
      checks++; if (redirect !== m_red) $display("[TB] FAIL rand_redirect%0d: got %b expected %b", i, redirect, m_red); else passed++;
`ifdef PC_CTRL_STATS_EN
      checks++; if (n_resolved !== 16'(m_nres)) $display("[TB] FAIL rand_nres%0d: got %0d expected %0d", i, n_resolved, m_nres); else passed++;
      checks++; if (n_taken !== 16'(m_ntak)) $display("[TB] FAIL rand_ntak%0d: got %0d expected %0d", i, n_taken, m_ntak); else passed++;
`endif
    end
    stall = 1'b0; flush = 1'b0; jon_d = 2'b00;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_direct();
    test_cond_branch();
    test_stall();
    test_priority();
    test_reset_mid();
`ifdef PC_CTRL_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter AW, 32, program-counter and operand width in bits (word-addressed PC).
REQ-002 Parameter RESOLVE_LAT, 2, cycles from decode of a conditional/indirect transfer to its resolution; legal range 1..7.
REQ-003 Parameter STAT_W, 16, width of statistics counters (REQ-026).
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rstd  in  1  reset, asynchronous, active-low.
REQ-006 stall  in  1  hold request from the pipeline; 1 freezes all state.
REQ-007 flush  in  1  discard any pending transfer resolution.
REQ-008 jon_d  in  2  decode-stage transfer class: 2'b01 direct jump, 2'b1x conditional/indirect pending, 2'b00 none.
REQ-009 addr_d  in  26  direct-jump byte address.
REQ-010 op  in  6  opcode of the resolving instruction.
REQ-011 os, ot  in  AW each  resolving source operands.
REQ-012 imm_dpl  in  AW  resolving byte displacement, two's complement.
REQ-013 pc_in  in  AW  word PC of the resolving instruction.
REQ-014 pc_out  out  AW  current fetch PC.
REQ-015 pending  out  1  high while resolution counter is nonzero.
REQ-016 redirect  out  1  one-cycle registered pulse: PC loaded from a resolved transfer that was taken.

Function
REQ-017 Next-PC priority per unstalled cycle: direct jump (jon_d==2'b01) -> addr_d>>2 zero-extended to AW; else counter==1 and flush==0 -> resolved target; else pc_out+1, wrapping modulo 2^AW.
REQ-018 nonbranch = pc_in+1; branch = nonbranch + (imm_dpl arithmetic-shifted right 2); both modulo 2^AW, so negative displacements are honoured.
REQ-019 Resolved target by op: 32 os==ot; 33 os!=ot; 34 os<ot unsigned; 35 os<=ot unsigned; 36 os<ot signed; 37 os<=ot signed -> branch if true else nonbranch; 42 -> os (indirect); any other op -> nonbranch.
REQ-020 Counter: jon_d[1]==1 loads RESOLVE_LAT; else decrements if nonzero; else holds 0. A new load while counter>0 restarts the count (the earlier transfer is superseded).
REQ-021 redirect asserts the cycle after a resolution whose target differs from nonbranch, and only if a direct jump did not win REQ-017 priority that cycle.
REQ-022 stall==1: pc_out, counter, redirect and statistics hold; jon_d and resolution inputs are ignored that cycle; redirect is held low.
REQ-023 flush==1 (unstalled): counter cleared to 0, no resolution that cycle, PC takes direct jump if present else pc_out+1; flush and jon_d[1] together -> counter loads RESOLVE_LAT (new transfer survives).
REQ-024 Combinational path only from inputs to next-state; all outputs registered.

Reset
REQ-025 rstd low, at any time including mid-resolution: pc_out=0, counter=0, pending=0, redirect=0, statistics=0; first fetch after release is address 0.

Configuration
REQ-026 Macro PC_CTRL_STATS_EN defined: add outputs n_resolved and n_taken (STAT_W each), incremented on every unstalled non-flushed resolution and every redirect respectively, saturating at all-ones; undefined: ports absent, no counters.

Structure
REQ-027 Shared package holds opcode constants (32..37, 42), jon_d encodings and the RESOLVE_LAT legal range.
REQ-028 Sub-module pc_cmp: combinational condition evaluator (op, os, ot -> taken), AW-parametrised.

Verification
REQ-029 Reset release, no transfers, 5 cycles -> pc_out 0,1,2,3,4; pending 0.
REQ-030 jon_d=01, addr_d=0x100 -> next pc_out=0x40; redirect stays 0.
REQ-031 RESOLVE_LAT=2, jon_d=10, at counter==1 op=36, os=-1, ot=0, pc_in=0x10, imm_dpl=-8 -> pc_out=0x0F, redirect=1 one cycle; with op=34 same operands -> pc_out=0x11, redirect=0.
REQ-032 Pending op=42, os=0x200, stall high 3 cycles at counter==1 -> pc_out and pending frozen; after stall drops -> pc_out=0x200.
REQ-033 counter==1 with jon_d=01 addr_d=0x80 simultaneously -> pc_out=0x20, counter 0, redirect 0; separately flush at counter==1 -> no redirect, pc_out+1.
REQ-034 rstd asserted while pending=1 -> all outputs 0 immediately; PC_CTRL_STATS_EN build: 3 taken of 5 resolutions -> n_resolved=5, n_taken=3.
